// File: rtl/data_ram_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module  : data_ram_ctrl                                                |
// | Brief   : word RAM behind a req/ready handshake with programmable wait |
// |           states; RAM_ACC_COUNT_EN adds the acc_count access counter.  |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
module data_ram_ctrl #(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 16,
  parameter int DEPTH       = 256,
  parameter int WAIT_STATES = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic              rw,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              ready,
  output logic              busy,
  output logic              err
`ifdef RAM_ACC_COUNT_EN
  ,
  output logic [15:0]       acc_count
`endif
);

  localparam int              c_IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] c_DEPTH     = (ADDR_W + 1)'(DEPTH);
  localparam logic [3:0]      c_WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  localparam logic [1:0] c_IDLE   = 2'd0;
  localparam logic [1:0] c_WAIT   = 2'd1;
  localparam logic [1:0] c_ACCESS = 2'd2;
  localparam logic [1:0] c_DONE   = 2'd3;
  localparam logic [1:0] c_FIRST  = (WAIT_STATES == 0) ? c_ACCESS : c_WAIT;

  logic [1:0]          r_state;
  logic [3:0]          r_wcnt;
  logic                r_rw;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic [DATA_W-1:0]   r_rdata;
  logic                r_err;
  logic [DATA_W-1:0]   r_mem [DEPTH];

  logic                w_in_range;
  logic [c_IDX_W-1:0]  w_idx;

  // Range check uses every address bit; only the low bits index the array.
  assign w_in_range = ({1'b0, r_addr} < c_DEPTH);
  assign w_idx      = r_addr[c_IDX_W-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= c_IDLE;
      r_wcnt  <= 4'd0;
      r_rdata <= '0;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        c_IDLE: begin
          if (req) begin
            r_rw    <= rw;
            r_addr  <= addr;
            r_wdata <= wdata;
            r_wcnt  <= c_WAIT_LOAD;
            r_state <= c_FIRST;
          end
        end
        c_WAIT: begin
          if (r_wcnt == 4'd0) begin
            r_state <= c_ACCESS;
          end else begin
            r_wcnt <= r_wcnt - 4'd1;
          end
        end
        c_ACCESS: begin
          r_err <= ~w_in_range;
          if (!r_rw) begin
            r_rdata <= w_in_range ? r_mem[w_idx] : '0;
          end
          r_state <= c_DONE;
        end
        c_DONE: begin
          r_err   <= 1'b0;
          r_state <= c_IDLE;
        end
        default: r_state <= c_IDLE;
      endcase
    end
  end

  // Array is never reset; a reset landing on the ACCESS edge blocks the store.
  always_ff @(posedge clk) begin
    if (!rst && (r_state == c_ACCESS) && r_rw && w_in_range) begin
      r_mem[w_idx] <= r_wdata;
    end
  end

`ifdef RAM_ACC_COUNT_EN
  logic [15:0] r_acc_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc_count <= 16'd0;
    end else if (r_state == c_ACCESS) begin
      r_acc_count <= r_acc_count + 16'd1;
    end
  end

  assign acc_count = r_acc_count;
`endif

  assign rdata = r_rdata;
  assign ready = (r_state == c_DONE);
  assign busy  = (r_state != c_IDLE);
  assign err   = r_err;

endmodule
`default_nettype wire

// File: tb/tb_data_ram_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module  : tb_data_ram_ctrl                                             |
// | Brief   : four DUTs (WAIT_STATES 0..3) against an array-based model.   |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
module tb_data_ram_ctrl;

  logic        clk;
  logic        rst   [4];
  logic        req   [4];
  logic        rw    [4];
  logic [15:0] addr  [4];
  logic [31:0] wdata [4];
  logic [31:0] rdata [4];
  logic        ready [4];
  logic        busy  [4];
  logic        err   [4];
`ifdef RAM_ACC_COUNT_EN
  logic [15:0] acc_count [4];
`endif

  int n_total = 0;
  int n_bad   = 0;

  // Reference state, one set per DUT (DUT k has WAIT_STATES = k).
  logic [31:0] ref_mem      [4][256];
  bit          ref_vld      [4][256];
  logic [31:0] ref_rdata    [4];
  bit          ref_rd_known [4];
  logic [15:0] ref_cnt      [4];

  for (genvar gi = 0; gi < 4; gi++) begin : g_dut
    data_ram_ctrl #(
      .DATA_W(32), .ADDR_W(16), .DEPTH(256), .WAIT_STATES(gi)
    ) u_dut (
      .clk(clk), .rst(rst[gi]), .req(req[gi]), .rw(rw[gi]),
      .addr(addr[gi]), .wdata(wdata[gi]), .rdata(rdata[gi]),
      .ready(ready[gi]), .busy(busy[gi]), .err(err[gi])
`ifdef RAM_ACC_COUNT_EN
      , .acc_count(acc_count[gi])
`endif
    );
  end

  always #5 clk = ~clk;

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic chk_cnt(input int k);
`ifdef RAM_ACC_COUNT_EN
    chk_eq("acc_count", {16'd0, acc_count[k]}, {16'd0, ref_cnt[k]});
`endif
  endtask

  // One complete handshake; meddle changes inputs and re-pulses req while busy.
  task automatic do_access(input int k, input logic wr, input logic [15:0] a,
                           input logic [31:0] d, input bit meddle);
    int          edges;
    bit          oor;
    bit          known;
    logic [31:0] exp_rd;
    oor = (a >= 16'd256);
    rw[k] = wr; addr[k] = a; wdata[k] = d; req[k] = 1'b1;
    @(posedge clk); #1;
    chk_eq("busy_rise", {31'd0, busy[k]}, 32'd1);
    if (meddle) begin
      addr[k] = a ^ 16'h0003; rw[k] = ~wr; wdata[k] = ~d;
    end else begin
      req[k] = 1'b0;
    end
    edges = 0;
    while (edges < 40) begin
      @(posedge clk); #1;
      edges++;
      req[k] = 1'b0;
      if (ready[k]) break;
      chk_eq("busy_wait", {31'd0, busy[k]}, 32'd1);
    end
    chk_eq("latency", edges, k + 1);
    chk_eq("busy_done", {31'd0, busy[k]}, 32'd1);
    chk_eq("err", {31'd0, err[k]}, {31'd0, oor});
    if (wr) begin
      if (!oor) begin
        if (ref_rd_known[k]) chk_eq("rdata_hold", rdata[k], ref_rdata[k]);
        ref_mem[k][a[7:0]] = d;
        ref_vld[k][a[7:0]] = 1'b1;
      end else begin
        ref_rd_known[k] = 1'b0;
      end
    end else begin
      if (oor) begin
        exp_rd = 32'd0; known = 1'b1;
      end else begin
        exp_rd = ref_mem[k][a[7:0]]; known = ref_vld[k][a[7:0]];
      end
      if (known) chk_eq("rdata", rdata[k], exp_rd);
      ref_rdata[k]    = exp_rd;
      ref_rd_known[k] = known;
    end
    ref_cnt[k] = ref_cnt[k] + 16'd1;
    @(posedge clk); #1;
    chk_eq("ready_drop", {31'd0, ready[k]}, 32'd0);
    chk_eq("busy_drop", {31'd0, busy[k]}, 32'd0);
    chk_eq("err_drop", {31'd0, err[k]}, 32'd0);
    chk_cnt(k);
    if (meddle) begin
      @(posedge clk); #1;
      chk_eq("no_second_access", {31'd0, busy[k]}, 32'd0);
      chk_cnt(k);
    end
  endtask

  initial begin
    int          k;
    int          sel;
    logic [15:0] ra;
    clk = 1'b0;
    for (int i = 0; i < 4; i++) begin
      rst[i] = 1'b1; req[i] = 1'b0; rw[i] = 1'b0; addr[i] = '0; wdata[i] = '0;
    end
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      chk_eq("rst_rdata", rdata[i], 32'd0);
      chk_eq("rst_ready", {31'd0, ready[i]}, 32'd0);
      chk_eq("rst_busy", {31'd0, busy[i]}, 32'd0);
      chk_eq("rst_err", {31'd0, err[i]}, 32'd0);
      ref_rdata[i] = 32'd0; ref_rd_known[i] = 1'b1; ref_cnt[i] = 16'd0;
      chk_cnt(i);
      rst[i] = 1'b0;
    end

    // Write then read with one wait state.
    do_access(1, 1'b1, 16'h0008, 32'h0000_0021, 1'b0);
    do_access(1, 1'b0, 16'h0008, 32'h0, 1'b0);

    // Out-of-range store must not alias onto word 0.
    do_access(1, 1'b1, 16'h0000, 32'h1234_5678, 1'b0);
    do_access(1, 1'b1, 16'h0100, 32'hDEAD_BEEF, 1'b0);
    do_access(1, 1'b0, 16'h0000, 32'h0, 1'b0);
    do_access(1, 1'b0, 16'h0100, 32'h0, 1'b0);

    // Latency sweep across all wait-state settings.
    for (int i = 0; i < 4; i++) begin
      do_access(i, 1'b1, 16'(16 + i), $urandom, 1'b0);
      do_access(i, 1'b0, 16'(16 + i), 32'h0, 1'b0);
    end

    // Inputs changed and req re-pulsed while busy are ignored.
    for (int i = 0; i < 4; i += 3) begin
      do_access(i, 1'b1, 16'h0005, 32'hAAAA_0005, 1'b0);
      do_access(i, 1'b1, 16'h0006, 32'hBBBB_0006, 1'b0);
      do_access(i, 1'b0, 16'h0005, 32'h0, 1'b1);
      do_access(i, 1'b0, 16'h0006, 32'h0, 1'b0);
    end

    // Reset during WAIT of a write aborts it.
    do_access(2, 1'b1, 16'h0003, 32'hCAFE_0003, 1'b0);
    rw[2] = 1'b1; addr[2] = 16'h0003; wdata[2] = 32'h5555_5555; req[2] = 1'b1;
    @(posedge clk); #1;
    chk_eq("abort_busy", {31'd0, busy[2]}, 32'd1);
    req[2] = 1'b0; rst[2] = 1'b1;
    @(posedge clk); #1;
    rst[2] = 1'b0;
    ref_rdata[2] = 32'd0; ref_rd_known[2] = 1'b1; ref_cnt[2] = 16'd0;
    chk_eq("abort_rdata", rdata[2], 32'd0);
    chk_cnt(2);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk_eq("abort_no_ready", {31'd0, ready[2]}, 32'd0);
      chk_eq("abort_idle", {31'd0, busy[2]}, 32'd0);
    end
    do_access(2, 1'b0, 16'h0003, 32'h0, 1'b0);

    // Randomized traffic, occasionally out of range.
    repeat (80) begin
      k   = int'($urandom_range(0, 3));
      sel = int'($urandom_range(0, 7));
      if (sel == 0) ra = 16'(256 + $urandom_range(0, 65279));
      else          ra = 16'($urandom_range(0, 15));
      do_access(k, 1'($urandom_range(0, 1)), ra, $urandom, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
